// File: rtl/obi_to_wb.sv
// ---------------------------------------------------------------------------
// obi_to_wb
//   Bridges an OBI slave port to a Wishbone classic master port. Exactly one
//   transaction is in flight: a granted OBI request becomes one WB classic
//   cycle, and the WB ack / err / timeout becomes exactly one OBI rvalid.
//   Sequence: IDLE (grant) -> BUS (cyc/stb high) -> RESP (rvalid) -> IDLE.
//
// Parameters
//   TIMEOUT    max BUS cycles waited for ack/err before forcing an error;
//              0 disables the timeout
//   ERR_RDATA  read data returned with an error or timeout response
//
// Ports
//   clk_i, wb_rst_i                 clock, synchronous active-high reset
//   req_i / gnt_o                   OBI request handshake
//   addr_i, we_i, be_i, wdata_i     OBI request payload
//   rvalid_o, rdata_o, err_o        OBI response
//   wbm_cyc_o, wbm_stb_o, wbm_we_o,
//   wbm_sel_o, wbm_adr_o, wbm_dat_o WB master request
//   wbm_dat_i, wbm_ack_i, wbm_err_i WB slave response
// ---------------------------------------------------------------------------
module obi_to_wb #(
   parameter int unsigned TIMEOUT   = 255,
   parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
   input  logic        clk_i,
   input  logic        wb_rst_i,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i
);

   localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUS  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_cyc;
   logic             r_we;
   logic [3:0]       r_sel;
   logic [31:0]      r_adr;
   logic [31:0]      r_dat;
   logic             r_rvalid;
   logic             r_err;
   logic [31:0]      r_rdata;

   logic w_timeout;
   logic w_term;

   // The counter equals the number of BUS cycles already spent without a
   // termination, so reaching TIMEOUT ends the cycle after TIMEOUT+1 strobes.
   assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LIMIT);
   assign w_term    = wbm_ack_i || wbm_err_i || w_timeout;

   // Grant is withheld during reset so no request is accepted on a reset edge.
   assign gnt_o = (r_state == S_IDLE) && !wb_rst_i;

   assign wbm_cyc_o = r_cyc;
   assign wbm_stb_o = r_cyc;
   assign wbm_we_o  = r_we;
   assign wbm_sel_o = r_sel;
   assign wbm_adr_o = r_adr;
   assign wbm_dat_o = r_dat;
   assign rvalid_o  = r_rvalid;
   assign err_o     = r_err;
   assign rdata_o   = r_rdata;

   always_ff @(posedge clk_i) begin
      // NOTE: all state here uses non-blocking assignments so every register
      // samples pre-edge values; blocking would make results order-dependent.
      if (wb_rst_i) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_cyc    <= 1'b0;
         r_we     <= 1'b0;
         r_sel    <= '0;
         r_adr    <= '0;
         r_dat    <= '0;
         r_rvalid <= 1'b0;
         r_err    <= 1'b0;
         r_rdata  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_i) begin
                  r_adr   <= addr_i;
                  r_we    <= we_i;
                  r_sel   <= be_i;
                  r_dat   <= wdata_i;
                  r_cyc   <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= S_BUS;
               end
            end
            S_BUS: begin
               if (w_term) begin
                  r_cyc    <= 1'b0;
                  r_rvalid <= 1'b1;
                  r_state  <= S_RESP;
                  // err dominates ack; no ack at all means a timeout.
                  if (wbm_err_i || !wbm_ack_i) begin
                     r_err   <= 1'b1;
                     r_rdata <= ERR_RDATA;
                  end else begin
                     r_err   <= 1'b0;
                     r_rdata <= r_we ? 32'd0 : wbm_dat_i;
                  end
               end else if (r_cnt != '1) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_RESP: begin
               r_rvalid <= 1'b0;
               r_err    <= 1'b0;
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_obi_to_wb.sv
// ---------------------------------------------------------------------------
// tb_obi_to_wb
//   Self-checking bench for obi_to_wb (TIMEOUT=4). A timeline model predicts,
//   per cycle, grant, bus window, response cycle and response contents from
//   each accepted request; it also plays the Wishbone slave. Directed cases
//   pin the model with literal expectations, then randomized traffic runs.
// ---------------------------------------------------------------------------
module tb_obi_to_wb;

   localparam int unsigned TO      = 4;
   localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;
   localparam int          NONE    = 99;

   logic        clk_i = 1'b0;
   logic        wb_rst_i;
   logic        req_i;
   logic        gnt_o;
   logic [31:0] addr_i;
   logic        we_i;
   logic [3:0]  be_i;
   logic [31:0] wdata_i;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [31:0] wbm_dat_i = '0;
   logic        wbm_ack_i = 1'b0;
   logic        wbm_err_i = 1'b0;

   obi_to_wb #(.TIMEOUT(TO), .ERR_RDATA(ERR_VAL)) dut (
      .clk_i     (clk_i),
      .wb_rst_i  (wb_rst_i),
      .req_i     (req_i),
      .gnt_o     (gnt_o),
      .addr_i    (addr_i),
      .we_i      (we_i),
      .be_i      (be_i),
      .wdata_i   (wdata_i),
      .rvalid_o  (rvalid_o),
      .rdata_o   (rdata_o),
      .err_o     (err_o),
      .wbm_cyc_o (wbm_cyc_o),
      .wbm_stb_o (wbm_stb_o),
      .wbm_we_o  (wbm_we_o),
      .wbm_sel_o (wbm_sel_o),
      .wbm_adr_o (wbm_adr_o),
      .wbm_dat_o (wbm_dat_o),
      .wbm_dat_i (wbm_dat_i),
      .wbm_ack_i (wbm_ack_i),
      .wbm_err_i (wbm_err_i)
   );

   always #5 clk_i = ~clk_i;

   int checks   = 0;
   int failures = 0;
   int cyc_n    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   // Plan for the next request: slave wait (NONE = never answer), err, ack+err, read data.
   int          p_wait = 0;
   bit          p_err  = 0;
   bit          p_both = 0;
   logic [31:0] p_dat  = '0;
   int          stray_mode = 0;   // 0 quiet, 1 ack every idle cycle, 2 random ack/err

   // Timeline model state.
   int          next_gnt = 0, bus_lo = 0, bus_hi = -1, rv = -1;
   int          grant_cnt = 0, last_grant_c = 0, resp_cnt = 0;
   bit          rst_prev = 1;
   logic [31:0] last_rdata = '0;
   logic [31:0] m_adr, m_dat, m_rd, e_rdata;
   logic [3:0]  m_sel;
   logic        m_we;
   int          m_wait;
   bit          m_err, m_both, e_err;

   initial begin
      forever begin
         @(posedge clk_i);
         cyc_n++;
      end
   end

   // Compare process: checks cycle cyc_n, drives the slave for that cycle and
   // advances the timeline for the coming edge.
   initial begin : model
      int c, t;
      bit in_bus;
      forever begin
         @(negedge clk_i);
         c = cyc_n;
         in_bus = (c >= bus_lo) && (c <= bus_hi);
         check("gnt", gnt_o, (!wb_rst_i && c >= next_gnt));
         check("cyc", wbm_cyc_o, in_bus);
         check("stb", wbm_stb_o, in_bus);
         if (in_bus) begin
            check("adr", wbm_adr_o, m_adr);
            check("sel", wbm_sel_o, m_sel);
            check("we",  wbm_we_o,  m_we);
            check("dat", wbm_dat_o, m_dat);
         end
         if (rst_prev) begin
            check("rst_adr", wbm_adr_o, 0);
            check("rst_sel", wbm_sel_o, 0);
            check("rst_we",  wbm_we_o,  0);
            check("rst_dat", wbm_dat_o, 0);
         end
         if (c == rv) begin
            check("rvalid", rvalid_o, 1);
            check("err",    err_o,    e_err);
            check("rdata",  rdata_o,  e_rdata);
            last_rdata = e_rdata;
            resp_cnt++;
         end else begin
            check("rvalid_idle", rvalid_o, 0);
            check("err_idle",    err_o,    0);
            check("rdata_hold",  rdata_o,  last_rdata);
         end

         // Wishbone slave behaviour for this cycle.
         wbm_dat_i = $urandom;
         if (in_bus) begin
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
            if ((c - bus_lo) == m_wait) begin
               wbm_ack_i = !m_err || m_both;
               wbm_err_i = m_err || m_both;
               wbm_dat_i = m_rd;
            end
         end else begin
            wbm_ack_i = (stray_mode == 1) || (stray_mode == 2 && ($urandom % 4) == 0);
            wbm_err_i = (stray_mode == 2) && (($urandom % 8) == 0);
         end

         // Timeline for the coming edge.
         rst_prev = wb_rst_i;
         if (wb_rst_i) begin
            bus_lo = 0; bus_hi = -1; rv = -1;
            next_gnt = c + 1;
            last_rdata = '0;
         end else if (req_i && c >= next_gnt) begin
            m_adr = addr_i; m_sel = be_i; m_we = we_i; m_dat = wdata_i;
            m_wait = p_wait; m_err = p_err; m_both = p_both; m_rd = p_dat;
            t = (p_wait == NONE) ? int'(TO) : p_wait;
            bus_lo = c + 1; bus_hi = c + 1 + t;
            rv = c + 2 + t; next_gnt = c + 3 + t;
            e_err = p_err || p_both || (p_wait == NONE);
            e_rdata = e_err ? ERR_VAL : (we_i ? 32'd0 : p_dat);
            last_grant_c = c;
            grant_cnt++;
         end
      end
   end

   task automatic wait_grant(input int gc0, output bit got);
      got = 0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(posedge clk_i); #1;
         if (grant_cnt != gc0) got = 1;
      end
      if (!got) check("grant_wait_expired", 0, 1);
   endtask

   // Issue one request; return latency grant->rvalid, strobe-cycle count,
   // response and the WB request seen in the first BUS cycle.
   task automatic do_txn(input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] wd, input int wt, input bit e, input bit both,
                         input logic [31:0] d, output int lat, output int stb_n,
                         output logic [31:0] rd, output logic re,
                         output logic [31:0] c_adr, output logic [31:0] c_dat,
                         output logic [3:0] c_sel);
      bit got;
      int gc0;
      gc0 = grant_cnt;
      lat = -1; stb_n = 0; rd = '0; re = 1'b0; c_adr = '0; c_dat = '0; c_sel = '0;
      p_wait = wt; p_err = e; p_both = both; p_dat = d;
      addr_i = a; we_i = w; be_i = b; wdata_i = wd; req_i = 1'b1;
      wait_grant(gc0, got);
      req_i = 1'b0; addr_i = $urandom; wdata_i = $urandom; be_i = 4'($urandom); we_i = 1'($urandom);
      if (got) begin
         c_adr = wbm_adr_o; c_dat = wbm_dat_o; c_sel = wbm_sel_o;
         for (int i = 0; i < 50; i++) begin
            if (wbm_stb_o) stb_n++;
            if (rvalid_o) begin
               lat = cyc_n - last_grant_c; rd = rdata_o; re = err_o;
               break;
            end
            @(posedge clk_i); #1;
         end
         if (lat < 0) check("rvalid_wait_expired", 0, 1);
      end
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      int lat, stb_n, nrv, ng, gc_seen;
      logic [31:0] rd, c_adr, c_dat;
      logic [3:0]  c_sel;
      logic        re;
      bit          got;
      logic [31:0] rq[$];

      wb_rst_i = 1'b1; req_i = 1'b0; addr_i = '0; we_i = 1'b0; be_i = '0; wdata_i = '0;
      @(posedge clk_i); #1;
      check("reset_gnt", gnt_o, 0);
      check("reset_cyc", wbm_cyc_o, 0);
      check("reset_rvalid", rvalid_o, 0);
      check("reset_rdata", rdata_o, 0);
      @(posedge clk_i); #1;
      wb_rst_i = 1'b0;
      @(posedge clk_i); #1;
      check("idle_gnt", gnt_o, 1);

      // Read, ack after 3 waiting BUS cycles.
      do_txn(32'h3000_0010, 1'b0, 4'hF, 32'h0, 3, 0, 0, 32'hCAFE_F00D,
             lat, stb_n, rd, re, c_adr, c_dat, c_sel);
      check("read_rdata", rd, 32'hCAFE_F00D);
      check("read_err", re, 0);
      check("read_lat", lat, 5);
      check("read_stb_cycles", stb_n, 4);
      check("read_adr", c_adr, 32'h3000_0010);

      // Write, ack in the first BUS cycle.
      do_txn(32'h3000_0020, 1'b1, 4'b0011, 32'h1234_5678, 0, 0, 0, 32'h0,
             lat, stb_n, rd, re, c_adr, c_dat, c_sel);
      check("write_dat", c_dat, 32'h1234_5678);
      check("write_sel", c_sel, 4'b0011);
      check("write_lat", lat, 2);
      check("write_err", re, 0);
      check("write_rdata", rd, 0);

      // Timeout, then a normal read.
      do_txn(32'h3000_0030, 1'b0, 4'hF, 32'h0, NONE, 0, 0, 32'h0,
             lat, stb_n, rd, re, c_adr, c_dat, c_sel);
      check("timeout_stb_cycles", stb_n, 5);
      check("timeout_err", re, 1);
      check("timeout_rdata", rd, 32'hDEAD_BEEF);
      check("timeout_lat", lat, 6);
      do_txn(32'h3000_0040, 1'b0, 4'hF, 32'h0, 1, 0, 0, 32'h0BAD_CAFE,
             lat, stb_n, rd, re, c_adr, c_dat, c_sel);
      check("after_timeout_rdata", rd, 32'h0BAD_CAFE);
      check("after_timeout_err", re, 0);
      check("after_timeout_lat", lat, 3);

      // ack and err together; err alone on a write.
      do_txn(32'h3000_0050, 1'b0, 4'hF, 32'h0, 2, 0, 1, 32'h5555_AAAA,
             lat, stb_n, rd, re, c_adr, c_dat, c_sel);
      check("ackerr_err", re, 1);
      check("ackerr_rdata", rd, 32'hDEAD_BEEF);
      do_txn(32'h3000_0060, 1'b1, 4'hF, 32'h7777_0000, 0, 1, 0, 32'h0,
             lat, stb_n, rd, re, c_adr, c_dat, c_sel);
      check("werr_err", re, 1);
      check("werr_rdata", rd, 32'hDEAD_BEEF);

      // Stray ack while idle.
      @(posedge clk_i); #1;
      stray_mode = 1; nrv = 0;
      repeat (6) begin
         @(posedge clk_i); #1;
         if (rvalid_o) nrv++;
      end
      stray_mode = 0;
      check("stray_no_rvalid", nrv, 0);

      // Reset in the middle of a BUS phase.
      p_wait = NONE; p_err = 0; p_both = 0; p_dat = '0;
      addr_i = 32'h3000_0070; we_i = 1'b0; be_i = 4'hF; req_i = 1'b1;
      wait_grant(grant_cnt, got);
      req_i = 1'b0;
      @(posedge clk_i); #1;
      wb_rst_i = 1'b1;
      @(posedge clk_i); #1;
      check("midbus_rst_cyc", wbm_cyc_o, 0);
      check("midbus_rst_stb", wbm_stb_o, 0);
      wb_rst_i = 1'b0;
      nrv = 0;
      repeat (10) begin
         @(posedge clk_i); #1;
         if (rvalid_o) nrv++;
      end
      check("midbus_rst_no_rvalid", nrv, 0);

      // Four back-to-back reads with req held high.
      nrv = 0; ng = 0; gc_seen = grant_cnt;
      p_wait = $urandom_range(0, 2); p_err = 0; p_both = 0; p_dat = 32'hA000_0000;
      addr_i = 32'h3000_0100; we_i = 1'b0; be_i = 4'hF; req_i = 1'b1;
      for (int i = 0; i < 80 && nrv < 4; i++) begin
         @(posedge clk_i); #1;
         if (rvalid_o) begin
            rq.push_back(rdata_o);
            nrv++;
         end
         if (grant_cnt != gc_seen) begin
            gc_seen = grant_cnt;
            ng++;
            if (ng < 4) begin
               p_wait = $urandom_range(0, 2);
               p_dat = 32'hA000_0000 + 32'(ng);
               addr_i = 32'h3000_0100 + 32'(4 * ng);
            end else begin
               req_i = 1'b0;
            end
         end
      end
      req_i = 1'b0;
      check("b2b_rvalids", nrv, 4);
      for (int k = 0; k < 4; k++)
         check("b2b_order", (k < rq.size()) ? rq[k] : 32'hFFFF_FFFF, 32'hA000_0000 + 32'(k));

      // Randomized traffic with random stray ack/err between cycles.
      stray_mode = 2;
      for (int n = 0; n < 150; n++) begin
         int r, wt;
         repeat ($urandom_range(0, 2)) begin
            addr_i = $urandom; wdata_i = $urandom;
            @(posedge clk_i); #1;
         end
         r = $urandom % 8;
         wt = (r == 0) ? NONE : $urandom_range(0, TO - 1);
         do_txn($urandom, 1'($urandom), 4'($urandom), $urandom, wt,
                ($urandom % 7) == 0, ($urandom % 9) == 0, $urandom,
                lat, stb_n, rd, re, c_adr, c_dat, c_sel);
      end
      stray_mode = 0;
      repeat (4) @(posedge clk_i);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
